// File: rtl/arm_pkg.sv
// Shared ARM pipeline types: word widths, PC step and the fetch-queue entry.
// Latency: n/a (types, constants and one pure function only).
// Backpressure: n/a.
// Contents: INSTR_W, ADDR_W, PC_INCR, ALIGN_MASK, PERF_W, fetch_entry_t, sat_add().
package arm_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;
  localparam int PERF_W  = 32;

  localparam logic [ADDR_W-1:0] PC_INCR    = 32'd4;
  // Low address bits that must be zero for a word-aligned fetch.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = 32'h0000_0003;

  typedef struct packed {
    logic [INSTR_W-1:0] instruction;
    logic [ADDR_W-1:0]  pc;           // fetch address + 4
  } fetch_entry_t;

  // Saturating add used by the optional performance counters.
  function automatic logic [PERF_W-1:0] sat_add(input logic [PERF_W-1:0] a,
                                                input logic [PERF_W-1:0] b);
    logic [PERF_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[PERF_W] ? {PERF_W{1'b1}} : s[PERF_W-1:0];
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch_entry_t between the IF and ID stages.
// Latency: an entry pushed at edge N is at the head after that edge (1 cycle); no bypass.
// Backpressure: caller must only push when not full or when popping in the same cycle.
// Ports: clk, rst (async active-low), push, pop, flush (clears all entries, wins over
//   push/pop), wr_entry, full, empty, head (registered storage, no input-to-output path);
//   count is present only when FETCH_PERF_CNT_EN is defined.
module fetch_queue
  import arm_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  fetch_entry_t                 wr_entry,
  output logic                         full,
  output logic                         empty,
`ifdef FETCH_PERF_CNT_EN
  output logic [$clog2(DEPTH+1)-1:0]   count,
`endif
  output fetch_entry_t                 head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt_q;

  // Storage is reset so the head reads as all-zero straight out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (push) begin
        mem[wr_ptr] <= wr_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = mem[rd_ptr];

`ifdef FETCH_PERF_CNT_EN
  assign count = cnt_q;
`endif

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, drives instruction memory and buffers fetched words for ID.
// Latency: word fetched in cycle N appears at the head in cycle N+1; outputs are registered.
// Backpressure: fetch continues while the queue has room; full & ~out_ready freezes PC and queue.
// Ports: clk, rst (async active-low), branch_taken/branch_addr (redirect + flush),
//   imem_address/imem_instruction (combinational memory), out_valid/out_ready/
//   out_instruction/out_pc (head of queue to ID).
// Optional macro FETCH_PERF_CNT_EN adds perf_fetched, perf_stall, perf_flushed (saturating).
module fetch_unit
  import arm_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC    = 32'h0,
  parameter int                QUEUE_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_addr,
  output logic [ADDR_W-1:0]  imem_address,
  input  logic [INSTR_W-1:0] imem_instruction,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instruction,
  output logic [ADDR_W-1:0]  out_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0]  perf_fetched,
  output logic [PERF_W-1:0]  perf_stall,
  output logic [PERF_W-1:0]  perf_flushed
`endif
);

  if (QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fetch_unit: QUEUE_DEPTH must be a power of two >= 2");
  end

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pc_incr;
  logic              deq;
  logic              enq;
  logic              q_full;
  logic              q_empty;
  fetch_entry_t      q_head;
  fetch_entry_t      q_wr;

`ifdef FETCH_PERF_CNT_EN
  logic [$clog2(QUEUE_DEPTH+1)-1:0] q_count;
`endif

  // Wraps naturally at 2^32: 32'hFFFFFFFC + 4 = 0.
  assign pc_incr = pc_q + PC_INCR;

  // A branch kills the head even if ID is ready, and blocks this cycle's fetch.
  // Enqueue into a full queue is allowed when the head leaves in the same cycle.
  assign deq = out_valid & out_ready & ~branch_taken;
  assign enq = ~branch_taken & (~q_full | deq);

  assign q_wr.instruction = imem_instruction;
  assign q_wr.pc          = pc_incr;

  always_comb begin
    pc_d = pc_q;
    if (branch_taken) begin
      pc_d = branch_addr & ~ALIGN_MASK;
    end else if (enq) begin
      pc_d = pc_incr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk      (clk),
    .rst      (rst),
    .push     (enq),
    .pop      (deq),
    .flush    (branch_taken),
    .wr_entry (q_wr),
    .full     (q_full),
    .empty    (q_empty),
`ifdef FETCH_PERF_CNT_EN
    .count    (q_count),
`endif
    .head     (q_head)
  );

  assign imem_address    = pc_q;
  assign out_valid       = ~q_empty;
  assign out_instruction = q_head.instruction;
  assign out_pc          = q_head.pc;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
      perf_flushed <= '0;
    end else begin
      if (enq) begin
        perf_fetched <= sat_add(perf_fetched, PERF_W'(1));
      end
      if (out_valid && !out_ready) begin
        perf_stall <= sat_add(perf_stall, PERF_W'(1));
      end
      // Every entry present when the branch lands is discarded.
      if (branch_taken) begin
        perf_flushed <= sat_add(perf_flushed, PERF_W'(q_count));
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Table-driven bench for fetch_unit with a combinational instruction-memory model.
// Each table row: the state expected at the start of a cycle, then the inputs for that cycle.
// A mid-stream asynchronous reset is exercised by hand after the table.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [31:0] imem_address;
  logic [31:0] imem_instruction;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
  logic [31:0] perf_flushed;
`endif

  int n_pass;
  int n_total;

  fetch_unit #(
    .RESET_PC    (32'h0),
    .QUEUE_DEPTH (2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .branch_taken     (branch_taken),
    .branch_addr      (branch_addr),
    .imem_address     (imem_address),
    .imem_instruction (imem_instruction),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_instruction  (out_instruction),
    .out_pc           (out_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched     (perf_fetched),
    .perf_stall       (perf_stall),
    .perf_flushed     (perf_flushed)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] imem(input logic [31:0] a);
    if (a == 32'h0) return 32'hE3A01A01;
    if (a == 32'h4) return 32'hE3A00014;
    return 32'hEA00_0000 ^ a;
  endfunction

  assign imem_instruction = imem(imem_address);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  typedef struct {
    bit          rst_before;
    bit          rdy;
    bit          br;
    logic [31:0] baddr;
    bit          chk_head;
    bit          exp_vld;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rb, bit rdy, bit br, logic [31:0] ba, bit ch, bit vld,
                              logic [31:0] ins, logic [31:0] pc, logic [31:0] addr);
    vec_t v;
    v.rst_before = rb;  v.rdy = rdy;    v.br = br;      v.baddr = ba;
    v.chk_head   = ch;  v.exp_vld = vld; v.exp_instr = ins; v.exp_pc = pc;
    v.exp_addr   = addr;
    return v;
  endfunction

  // Reset is asserted between clock edges and checked before any edge can mask it.
  task automatic do_reset(input string tag);
    rst          = 1'b0;
    out_ready    = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = 32'h0;
    #1;
    check({tag, "_valid"}, {31'b0, out_valid}, 32'h0);
    check({tag, "_instr"}, out_instruction, 32'h0);
    check({tag, "_pc"},    out_pc,          32'h0);
    check({tag, "_addr"},  imem_address,    32'h0);
`ifdef FETCH_PERF_CNT_EN
    check({tag, "_perf_fetched"}, perf_fetched, 32'h0);
    check({tag, "_perf_stall"},   perf_stall,   32'h0);
    check({tag, "_perf_flushed"}, perf_flushed, 32'h0);
`endif
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_pass       = 0;
    n_total      = 0;
    rst          = 1'b0;
    out_ready    = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = 32'h0;

    // Basic streaming from reset
    vecs.push_back(mk(1, 1, 0, 32'h0, 1, 0, 32'h0,        32'h0,  32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0, 1, 1, 32'hE3A01A01, 32'h4,  32'h4));
    vecs.push_back(mk(0, 1, 0, 32'h0, 1, 1, 32'hE3A00014, 32'h8,  32'h8));
    vecs.push_back(mk(0, 1, 0, 32'h0, 1, 1, imem(32'h8),  32'hC,  32'hC));
    // ID stalled for 5 cycles: queue fills, PC holds at 8
    vecs.push_back(mk(1, 0, 0, 32'h0, 1, 0, 32'h0,        32'h0,  32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0, 1, 1, 32'hE3A01A01, 32'h4,  32'h4));
    vecs.push_back(mk(0, 0, 0, 32'h0, 1, 1, 32'hE3A01A01, 32'h4,  32'h8));
    vecs.push_back(mk(0, 0, 0, 32'h0, 1, 1, 32'hE3A01A01, 32'h4,  32'h8));
    vecs.push_back(mk(0, 0, 0, 32'h0, 1, 1, 32'hE3A01A01, 32'h4,  32'h8));
    // Release: @0, @4, @8 with no gap
    vecs.push_back(mk(0, 1, 0, 32'h0, 1, 1, 32'hE3A01A01, 32'h4,  32'h8));
    vecs.push_back(mk(0, 1, 0, 32'h0, 1, 1, 32'hE3A00014, 32'h8,  32'hC));
    // Branch to 0x43 with full queue and ID ready: head killed, no enqueue
    vecs.push_back(mk(0, 1, 1, 32'h43, 1, 1, imem(32'h8), 32'hC,  32'h10));
    vecs.push_back(mk(0, 1, 0, 32'h0,  0, 0, 32'h0,       32'h0,  32'h40));
    vecs.push_back(mk(0, 0, 0, 32'h0,  1, 1, imem(32'h40), 32'h44, 32'h44));
    // Branch to the last word of the address space
    vecs.push_back(mk(0, 0, 1, 32'hFFFF_FFFC, 1, 1, imem(32'h40), 32'h44, 32'h48));
    vecs.push_back(mk(0, 1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 32'hFFFF_FFFC));
    vecs.push_back(mk(0, 1, 0, 32'h0, 1, 1, imem(32'hFFFF_FFFC), 32'h0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0, 1, 1, 32'hE3A01A01, 32'h4, 32'h4));
    vecs.push_back(mk(0, 0, 0, 32'h0, 1, 1, 32'hE3A01A01, 32'h4, 32'h8));

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst_before) begin
        do_reset($sformatf("rst%0d", i));
      end
`ifdef FETCH_PERF_CNT_EN
      // Stall run then one branch that killed two entries.
      if (i == 12) begin
        check("perf_fetched_v12", perf_fetched, 32'd4);
        check("perf_stall_v12",   perf_stall,   32'd4);
        check("perf_flushed_v12", perf_flushed, 32'd2);
      end
      if (i == 15) begin
        check("perf_flushed_v15", perf_flushed, 32'd4);
      end
`endif
      check($sformatf("v%0d_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].exp_vld});
      check($sformatf("v%0d_addr", i),  imem_address, vecs[i].exp_addr);
      if (vecs[i].chk_head) begin
        check($sformatf("v%0d_instr", i), out_instruction, vecs[i].exp_instr);
        check($sformatf("v%0d_pc", i),    out_pc,          vecs[i].exp_pc);
      end
      out_ready    = vecs[i].rdy;
      branch_taken = vecs[i].br;
      branch_addr  = vecs[i].baddr;
      @(negedge clk);
    end

    // Queue holds two entries here; reset must clear everything before the next edge.
    check("pre_midrst_valid", {31'b0, out_valid}, 32'h1);
    #2;
    do_reset("midrst");
    // First fetch after mid-stream reset restarts at RESET_PC.
    out_ready = 1'b1;
    @(negedge clk);
    check("post_midrst_valid", {31'b0, out_valid}, 32'h1);
    check("post_midrst_instr", out_instruction, 32'hE3A01A01);
    check("post_midrst_pc",    out_pc,          32'h4);
    check("post_midrst_addr",  imem_address,    32'h4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
